bm_axil_io_bridge: RTL and testbench
====================================

# bm_axil_io_bridge

AXI4-Lite slave that connects the processing system to the BondMachine core's I/O handshake ports. It sits directly downstream of the AXI master (PS or VIP master in simulation) and upstream of the BondMachine core. CPU writes become validated core inputs; core outputs are captured into readable registers. A status register exposes the pending, new-data and overrun flags.

## Interface
- C_S_AXI_DATA_WIDTH, 32: AXI data width; fixed at 32, other values unsupported.
- C_S_AXI_ADDR_WIDTH, 4: AXI address width; only bits [3:2] decoded.
- BM_WIDTH, 32: width of core data ports, ≤ 32; register bits above it read 0 and ignore writes.

Ports:
- ACLK  in  1  sole clock.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite slave, widths per parameters; PROT ignored.
- bm_i0, bm_i1  out  BM_WIDTH  core input data.
- bm_i0_valid, bm_i1_valid  out  1  input data valid to core.
- bm_i0_recv, bm_i1_recv  in  1  core has taken input.
- bm_o0  in  BM_WIDTH  core output data.
- bm_o0_valid  in  1  core output valid.
- bm_o0_recv  out  1  one-cycle capture acknowledge.
- irq  out  1  present only with BM_AXIL_IRQ_EN.

## Operation
- Register map (word offsets): 0x0 IN0 RW, 0x4 IN1 RW, 0x8 OUT0 RO, 0xC STATUS.
- STATUS bits: [0] IN0 pending (=bm_i0_valid), [1] IN1 pending, [2] OUT0 new, [3] OUT0 overrun (W1C); others read 0.
- Write IN0/IN1: per-byte WSTRB merge into register; sets pending. Pending clears on the cycle after bm_iX_recv sampled high.
- Write to OUT0 ignored; write to STATUS only clears bit3 where WDATA[3]=1. All responses OKAY (BRESP/RRESP = 2'b00).
- Capture: when bm_o0_valid=1 and bm_o0_recv not asserted last cycle, OUT0 ← bm_o0, new ← 1, bm_o0_recv pulses one cycle. If new already 1 at capture, overrun ← 1.
- Read of OUT0 clears new (after returning data). Read of STATUS has no side effect.
- Write FSM: IDLE → (AW and W latched independently, either order or same cycle) → RESP (register updated on entry, BVALID=1) → IDLE on BREADY. AWREADY/WREADY low once their channel is latched and throughout RESP.
- Read FSM: IDLE (ARREADY=1) → DATA (RVALID=1, RDATA held) → IDLE on RREADY.

## Timing
- Reset: all AXI READY/VALID outputs 0 except AWREADY=WREADY=ARREADY=1 one cycle after deassertion; RDATA=0, BRESP=RRESP=0; IN0/IN1/OUT0=0; all STATUS flags 0; bm_iX_valid=0, bm_o0_recv=0, irq=0.
- Write: AW+W accepted in cycle N → BVALID and register update visible cycle N+1; bm_iX_valid rises N+1.
- Read: AR accepted cycle N → RVALID cycle N+1; minimum one idle cycle between back-to-back reads is not required (ARREADY re-asserts the cycle RREADY completes).
- bm_iX_recv and new write to same reg in same cycle: write wins, pending stays 1, new data presented.
- Capture and OUT0 read-completion same cycle: read returns old value, new stays 1.
- Capture and STATUS W1C same cycle: overrun set wins.
- Reset mid-transaction: all FSMs return to IDLE immediately; outstanding responses dropped.

## Configuration
- BM_AXIL_IRQ_EN defined: irq port exists; irq = registered (new | overrun), updates one cycle after flag change, level until cleared.
- Not defined: irq port and logic absent; flags only pollable via STATUS.

## Test plan
- Reset release → read 0xC returns 0x0; bm_i0_valid=0, bm_o0_recv=0.
- Write 0x0=0x00000001, WSTRB=0xF → BVALID next cycle, bm_i0=1, bm_i0_valid=1, STATUS=0x1; pulse bm_i0_recv → STATUS=0x0.
- Write 0x4=0xAABBCCDD then WSTRB=0x1 with 0x11 → IN1 reads 0xAABBCC11.
- bm_o0=0x1234 with valid → bm_o0_recv one cycle, STATUS=0x4; read 0x8 returns 0x1234, STATUS then 0x0.
- Two captures (0x5, 0x6) without read → OUT0=0x6, STATUS=0xC; write 0xC=0x8 → STATUS=0x4; with BM_AXIL_IRQ_EN irq stays 1 until OUT0 read.
- AW presented 3 cycles before W, BREADY held low 4 cycles → single B response, AWREADY/WREADY low until BREADY handshake.

Source files
------------

// File: rtl/bm_axil_io_bridge.sv
// bm_axil_io_bridge: AXI4-Lite slave bridging the processing system to the
// BondMachine core I/O handshake ports.
//   0x0 IN0  (RW)  -> bm_i0 / bm_i0_valid
//   0x4 IN1  (RW)  -> bm_i1 / bm_i1_valid
//   0x8 OUT0 (RO)  <- bm_o0 captured on bm_o0_valid
//   0xC STATUS     [0] IN0 pending, [1] IN1 pending, [2] OUT0 new, [3] overrun (W1C)
// Optional feature macro: BM_AXIL_IRQ_EN adds a level irq = registered (new | overrun).
module bm_axil_io_bridge #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int BM_WIDTH           = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  // write response channel
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  // BondMachine core side
  output logic [BM_WIDTH-1:0]             bm_i0,
  output logic [BM_WIDTH-1:0]             bm_i1,
  output logic                            bm_i0_valid,
  output logic                            bm_i1_valid,
  input  logic                            bm_i0_recv,
  input  logic                            bm_i1_recv,
  input  logic [BM_WIDTH-1:0]             bm_o0,
  input  logic                            bm_o0_valid,
  output logic                            bm_o0_recv
`ifdef BM_AXIL_IRQ_EN
  ,
  output logic                            irq
`endif
);

  // Register word offsets (address bits [3:2])
  localparam logic [1:0] A_IN0  = 2'd0;
  localparam logic [1:0] A_IN1  = 2'd1;
  localparam logic [1:0] A_OUT0 = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  // Bits above BM_WIDTH are held at zero in every data register
  localparam logic [31:0] BM_MASK = (BM_WIDTH >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << BM_WIDTH) - 32'd1);

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

  // Byte-lane merge of a write into the previous register contents
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        r[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        r[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return r;
  endfunction

  // Write channel state
  wstate_e     wstate_q;
  logic        awready_q, wready_q, bvalid_q;
  logic        aw_got_q, w_got_q;
  logic [1:0]  awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  // Read channel state
  rstate_e     rstate_q;
  logic        arready_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  raddr_q;

  // Register file and flags
  logic [31:0] in0_q, in1_q, out0_q;
  logic        pend0_q, pend1_q, new_q, ovr_q, o0_recv_q;

  // Combinational helpers
  logic        aw_hs_s, w_hs_s, aw_have_s, w_have_s, wr_commit_s;
  logic [1:0]  wr_addr_s;
  logic [31:0] wr_data_s, wr_old_s, wr_merged_s;
  logic [3:0]  wr_strb_s;
  logic        wr_in0_s, wr_in1_s, w1c_s;
  logic        ar_hs_s, rd_done_s, rd_out0_clr_s, cap_s;
  logic [31:0] rd_mux_s, bm_o0_ext_s;

  // Write-side handshake tracking and commit decode
  always_comb begin
    aw_hs_s     = S_AXI_AWVALID & awready_q;
    w_hs_s      = S_AXI_WVALID & wready_q;
    aw_have_s   = aw_got_q | aw_hs_s;
    w_have_s    = w_got_q | w_hs_s;
    wr_commit_s = (wstate_q == W_IDLE) & aw_have_s & w_have_s;
    if (aw_hs_s) begin
      wr_addr_s = S_AXI_AWADDR[3:2];
    end else begin
      wr_addr_s = awaddr_q;
    end
    if (w_hs_s) begin
      wr_data_s = S_AXI_WDATA;
      wr_strb_s = S_AXI_WSTRB;
    end else begin
      wr_data_s = wdata_q;
      wr_strb_s = wstrb_q;
    end
    if (wr_addr_s == A_IN1) begin
      wr_old_s = in1_q;
    end else begin
      wr_old_s = in0_q;
    end
    wr_merged_s = strb_merge(wr_old_s, wr_data_s, wr_strb_s) & BM_MASK;
    wr_in0_s    = wr_commit_s & (wr_addr_s == A_IN0);
    wr_in1_s    = wr_commit_s & (wr_addr_s == A_IN1);
    w1c_s       = wr_commit_s & (wr_addr_s == A_STAT) & wr_data_s[3];
  end

  // Read-side handshake decode, capture qualifier and read data mux
  always_comb begin
    ar_hs_s       = S_AXI_ARVALID & arready_q;
    rd_done_s     = (rstate_q == R_DATA) & S_AXI_RREADY;
    rd_out0_clr_s = rd_done_s & (raddr_q == A_OUT0);
    cap_s         = bm_o0_valid & ~o0_recv_q;
    bm_o0_ext_s   = 32'h0;
    bm_o0_ext_s[BM_WIDTH-1:0] = bm_o0;
    case (S_AXI_ARADDR[3:2])
      A_IN0:   rd_mux_s = in0_q;
      A_IN1:   rd_mux_s = in1_q;
      A_OUT0:  rd_mux_s = out0_q;
      A_STAT:  rd_mux_s = {28'h0, ovr_q, new_q, pend1_q, pend0_q};
      default: rd_mux_s = 32'h0;
    endcase
  end

  // Write FSM: latch AW and W independently, respond once both are held
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= 2'd0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs_s) begin
            awaddr_q <= S_AXI_AWADDR[3:2];
          end
          if (w_hs_s) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
          end
          if (wr_commit_s) begin
            wstate_q  <= W_RESP;
            bvalid_q  <= 1'b1;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
          end else begin
            aw_got_q  <= aw_have_s;
            w_got_q   <= w_have_s;
            awready_q <= ~aw_have_s;
            wready_q  <= ~w_have_s;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            wstate_q  <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: begin
          wstate_q  <= W_IDLE;
          bvalid_q  <= 1'b0;
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          aw_got_q  <= 1'b0;
          w_got_q   <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: accept AR, hold RDATA until the master takes it
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      raddr_q   <= 2'd0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ar_hs_s) begin
            rstate_q  <= R_DATA;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rdata_q   <= rd_mux_s;
            raddr_q   <= S_AXI_ARADDR[3:2];
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rstate_q  <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: begin
          rstate_q  <= R_IDLE;
          rvalid_q  <= 1'b0;
          arready_q <= 1'b0;
        end
      endcase
    end
  end

  // Input registers and pending flags; a new write beats a same-cycle recv
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      in0_q   <= 32'h0;
      in1_q   <= 32'h0;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
    end else begin
      if (wr_in0_s) begin
        in0_q   <= wr_merged_s;
        pend0_q <= 1'b1;
      end else if (bm_i0_recv) begin
        pend0_q <= 1'b0;
      end
      if (wr_in1_s) begin
        in1_q   <= wr_merged_s;
        pend1_q <= 1'b1;
      end else if (bm_i1_recv) begin
        pend1_q <= 1'b0;
      end
    end
  end

  // Output capture, new/overrun flags and one-cycle capture acknowledge
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      out0_q    <= 32'h0;
      new_q     <= 1'b0;
      ovr_q     <= 1'b0;
      o0_recv_q <= 1'b0;
    end else begin
      o0_recv_q <= cap_s;
      if (cap_s) begin
        out0_q <= bm_o0_ext_s & BM_MASK;
        new_q  <= 1'b1;
      end else if (rd_out0_clr_s) begin
        new_q  <= 1'b0;
      end
      // A capture over unread data beats a same-cycle W1C
      if (cap_s && new_q) begin
        ovr_q <= 1'b1;
      end else if (w1c_s) begin
        ovr_q <= 1'b0;
      end
    end
  end

`ifdef BM_AXIL_IRQ_EN
  logic irq_q;

  // Level interrupt tracking the new/overrun flags one cycle later
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= new_q | ovr_q;
    end
  end

  assign irq = irq_q;
`endif

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign bm_i0         = in0_q[BM_WIDTH-1:0];
  assign bm_i1         = in1_q[BM_WIDTH-1:0];
  assign bm_i0_valid   = pend0_q;
  assign bm_i1_valid   = pend1_q;
  assign bm_o0_recv    = o0_recv_q;

  // Protection bits and byte-offset address bits carry no meaning here
  logic unused_s;
  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_bm_axil_io_bridge.sv
// Directed-vector bench for bm_axil_io_bridge (optionally with BM_AXIL_IRQ_EN).
module tb_bm_axil_io_bridge;

  logic        ACLK, ARESETN;
  logic [3:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic        S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [31:0] bm_i0, bm_i1, bm_o0;
  logic        bm_i0_valid, bm_i1_valid, bm_i0_recv, bm_i1_recv;
  logic        bm_o0_valid, bm_o0_recv;
`ifdef BM_AXIL_IRQ_EN
  logic        irq;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd;

  bm_axil_io_bridge #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .BM_WIDTH(32)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .bm_i0(bm_i0), .bm_i1(bm_i1), .bm_i0_valid(bm_i0_valid), .bm_i1_valid(bm_i1_valid),
    .bm_i0_recv(bm_i0_recv), .bm_i1_recv(bm_i1_recv),
    .bm_o0(bm_o0), .bm_o0_valid(bm_o0_valid), .bm_o0_recv(bm_o0_recv)
`ifdef BM_AXIL_IRQ_EN
    , .irq(irq)
`endif
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_done, w_done;
    int n;
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = d;  S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1'b1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1'b1;
      tick();
      if (aw_done) S_AXI_AWVALID = 1'b0;
      if (w_done) S_AXI_WVALID = 1'b0;
      n++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check_val("wr_accept", {30'h0, aw_done, w_done}, 32'h3);
    check_val("wr_bvalid_lat", {31'h0, S_AXI_BVALID}, 32'h1);
    check_val("wr_bresp", {30'h0, S_AXI_BRESP}, 32'h0);
    tick();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    logic done;
    int n;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    done = 1'b0; n = 0;
    while (!done && n < 20) begin
      done = S_AXI_ARREADY;
      tick();
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    check_val("rd_accept", {31'h0, done}, 32'h1);
    check_val("rd_rvalid_lat", {31'h0, S_AXI_RVALID}, 32'h1);
    check_val("rd_rresp", {30'h0, S_AXI_RRESP}, 32'h0);
    d = S_AXI_RDATA;
    tick();
    S_AXI_RREADY = 1'b0;
  endtask

  // One-cycle core output presentation
  task automatic capture(input logic [31:0] v);
    bm_o0 = v; bm_o0_valid = 1'b1;
    tick();
    bm_o0_valid = 1'b0;
    check_val("cap_recv_pulse", {31'h0, bm_o0_recv}, 32'h1);
    tick();
    check_val("cap_recv_drop", {31'h0, bm_o0_recv}, 32'h0);
  endtask

  initial begin
    ARESETN = 1'b0;
    S_AXI_AWADDR = 4'h0; S_AXI_AWPROT = 3'd0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = 4'h0; S_AXI_ARPROT = 3'd0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    bm_i0_recv = 1'b0; bm_i1_recv = 1'b0; bm_o0 = 32'h0; bm_o0_valid = 1'b0;

    // Reset state
    repeat (3) tick();
    check_val("rst_awready", {31'h0, S_AXI_AWREADY}, 32'h0);
    check_val("rst_arready", {31'h0, S_AXI_ARREADY}, 32'h0);
    ARESETN = 1'b1;
    tick();
    check_val("rel_ready", {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);
    check_val("rel_valid", {30'h0, S_AXI_BVALID, S_AXI_RVALID}, 32'h0);
    check_val("rel_bm_flags", {30'h0, bm_i0_valid, bm_o0_recv}, 32'h0);
    axi_read(4'hC, rd); check_val("rst_status", rd, 32'h0);

    // IN0 write and recv handshake
    axi_write(4'h0, 32'h0000_0001, 4'hF);
    check_val("in0_data", bm_i0, 32'h1);
    check_val("in0_valid", {31'h0, bm_i0_valid}, 32'h1);
    axi_read(4'hC, rd); check_val("status_pend0", rd, 32'h1);
    bm_i0_recv = 1'b1; tick(); bm_i0_recv = 1'b0;
    check_val("in0_valid_clr", {31'h0, bm_i0_valid}, 32'h0);
    axi_read(4'hC, rd); check_val("status_clr0", rd, 32'h0);

    // IN1 byte-strobe merge
    axi_write(4'h4, 32'hAABB_CCDD, 4'hF);
    axi_write(4'h4, 32'h0000_0011, 4'h1);
    axi_read(4'h4, rd); check_val("in1_merge_rd", rd, 32'hAABB_CC11);
    check_val("in1_merge_port", bm_i1, 32'hAABB_CC11);
    axi_read(4'hC, rd); check_val("status_pend1", rd, 32'h2);
    bm_i1_recv = 1'b1; tick(); bm_i1_recv = 1'b0;
    check_val("in1_valid_clr", {31'h0, bm_i1_valid}, 32'h0);

    // Single capture then read
    capture(32'h0000_1234);
    axi_read(4'hC, rd); check_val("status_new", rd, 32'h4);
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF);
    axi_read(4'h8, rd); check_val("out0_rd", rd, 32'h1234);
    axi_read(4'hC, rd); check_val("status_after_rd", rd, 32'h0);

    // Overrun, W1C, irq level
    capture(32'h5);
    capture(32'h6);
    axi_read(4'hC, rd); check_val("status_ovr", rd, 32'hC);
`ifdef BM_AXIL_IRQ_EN
    check_val("irq_set", {31'h0, irq}, 32'h1);
`endif
    axi_write(4'hC, 32'h0000_0008, 4'hF);
    axi_read(4'hC, rd); check_val("status_w1c", rd, 32'h4);
`ifdef BM_AXIL_IRQ_EN
    check_val("irq_hold", {31'h0, irq}, 32'h1);
`endif
    axi_read(4'h8, rd); check_val("out0_last", rd, 32'h6);
    axi_read(4'hC, rd); check_val("status_idle", rd, 32'h0);
`ifdef BM_AXIL_IRQ_EN
    check_val("irq_clr", {31'h0, irq}, 32'h0);
`endif

    // AW three cycles ahead of W, BREADY held low four cycles
    S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1; S_AXI_BREADY = 1'b0;
    tick(); S_AXI_AWVALID = 1'b0;
    check_val("aw_only_awready", {31'h0, S_AXI_AWREADY}, 32'h0);
    check_val("aw_only_wready", {31'h0, S_AXI_WREADY}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("aw_wait", {30'h0, S_AXI_AWREADY, S_AXI_BVALID}, 32'h0);
    end
    S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick(); S_AXI_WVALID = 1'b0;
    check_val("late_w_bvalid", {31'h0, S_AXI_BVALID}, 32'h1);
    check_val("late_w_in0", bm_i0, 32'h55);
    for (int i = 0; i < 4; i++) begin
      check_val("bstall", {29'h0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 32'h4);
      tick();
    end
    S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
    check_val("bdone", {29'h0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 32'h3);
    tick();
    check_val("single_b", {31'h0, S_AXI_BVALID}, 32'h0);

    // Write and recv in the same cycle: write wins
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1; bm_i0_recv = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; bm_i0_recv = 1'b0;
    check_val("wr_vs_recv_valid", {31'h0, bm_i0_valid}, 32'h1);
    check_val("wr_vs_recv_data", bm_i0, 32'h77);
    tick(); S_AXI_BREADY = 1'b0;
    bm_i0_recv = 1'b1; tick(); bm_i0_recv = 1'b0;
    check_val("recv_after", {31'h0, bm_i0_valid}, 32'h0);

    // Capture and W1C in the same cycle: overrun stays set
    capture(32'hA);
    capture(32'hB);
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h8; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    bm_o0 = 32'hC; bm_o0_valid = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; bm_o0_valid = 1'b0;
    check_val("cap_w1c_recv", {31'h0, bm_o0_recv}, 32'h1);
    tick(); S_AXI_BREADY = 1'b0;
    axi_read(4'hC, rd); check_val("cap_w1c_status", rd, 32'hC);

    // Capture on the OUT0 read-completion cycle: old data returned, new stays
    S_AXI_ARADDR = 4'h8; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    tick(); S_AXI_ARVALID = 1'b0;
    check_val("race_rvalid", {31'h0, S_AXI_RVALID}, 32'h1);
    rd = S_AXI_RDATA;
    bm_o0 = 32'hD; bm_o0_valid = 1'b1;
    tick(); bm_o0_valid = 1'b0; S_AXI_RREADY = 1'b0;
    check_val("race_rdata", rd, 32'hC);
    check_val("race_rvalid_drop", {31'h0, S_AXI_RVALID}, 32'h0);
    axi_read(4'hC, rd); check_val("race_status", rd, 32'hC);
    axi_read(4'h8, rd); check_val("race_out0", rd, 32'hD);
    axi_read(4'hC, rd); check_val("race_status2", rd, 32'h8);
    axi_write(4'hC, 32'h8, 4'hF);
    axi_read(4'hC, rd); check_val("race_status3", rd, 32'h0);

    // Reset in the middle of a write
    axi_write(4'h4, 32'h99, 4'hF);
    S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
    tick(); S_AXI_AWVALID = 1'b0;
    ARESETN = 1'b0; #1;
    check_val("mid_rst_flags", {30'h0, bm_i1_valid, S_AXI_AWREADY}, 32'h0);
    tick(); ARESETN = 1'b1;
    tick();
    check_val("mid_rst_ready", {28'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID}, 32'hC);
    check_val("mid_rst_in1", bm_i1, 32'h0);
    axi_read(4'hC, rd); check_val("mid_rst_status", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
